// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared states and constants for the programmable clock divider
package clkdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  localparam int DIV_W = 8;
  localparam int DIV_DEFAULT = 16;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/div_period_counter.sv
// div_period_counter: period counter, wrap detect and registered divided clock level
module div_period_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         run_d,
  input  logic [W-1:0] n,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         clkout_q
);
  logic [W-1:0] count_d;
  logic [W:0] half;
  always_comb begin
    wrap = run && count == n - 1'b1;
    count_d = run && !wrap ? count + 1'b1 : '0;
    half = ({1'b0, n} + 1'b1) >> 1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      clkout_q <= 1'b0;
    end else begin
      count <= count_d;
      clkout_q <= run_d && {1'b0, count_d} < half;
    end
  end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time programmable clock divider with boundary-aligned ratio changes
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int W = DIV_W,
  parameter int DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clkout,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);
  state_t state, state_d;
  logic [W-1:0] pend, pend_d, div_d, count;
  logic wrap, legal, acc;
  div_period_counter #(.W(W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .run(busy),
    .run_d(state_d != IDLE),
    .n(cur_div),
    .count(count),
    .wrap(wrap),
    .clkout_q(clkout)
  );
  always_comb begin
    cfg_ready = state != PEND;
    busy = state != IDLE;
    tick = busy && count == cur_div - 1'b1;
    legal = cfg_div >= W'(MIN_DIV);
    acc = cfg_valid && cfg_ready && legal;
    state_d = state;
    div_d = cur_div;
    pend_d = pend;
    case (state)
      IDLE: begin
        div_d = acc ? cfg_div : cur_div;
        state_d = enable ? RUN : IDLE;
      end
      RUN: begin
        if (wrap && !enable) begin
          state_d = IDLE;
          div_d = acc ? cfg_div : cur_div;
        end else if (acc) begin
          pend_d = cfg_div;
          state_d = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          div_d = pend;
          state_d = enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cur_div <= W'(DEFAULT_DIV);
      pend <= '0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_d;
      cur_div <= div_d;
      pend <= pend_d;
      cfg_err <= cfg_valid && cfg_ready && !legal;
    end
  end
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: scoreboard bench for clkdiv_ctrl with directed pattern checks
module tb_clkdiv_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_div = 8'd0;
  logic cfg_ready, cfg_err, clkout, tick, busy;
  logic [7:0] cur_div;
  int n_run = 0;
  int n_fail = 0;
  int ms = 0, mc = 0, md = 16, mp = 0, me = 0;
  logic [12:0] scb[$];
  logic [31:0] cp, tp;
  logic cp0;
  clkdiv_ctrl #(.W(8), .DEFAULT_DIV(16)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .clkout(clkout),
    .tick(tick),
    .busy(busy),
    .cur_div(cur_div)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    int ns, nc, nd, np;
    bit acc, last;
    if (reset) begin
      ms = 0; mc = 0; md = 16; mp = 0; me = 0;
      return;
    end
    acc = cfg_valid && ms != 2 && cfg_div >= 2;
    me = (cfg_valid && ms != 2 && cfg_div < 2) ? 1 : 0;
    last = ms != 0 && mc == md - 1;
    ns = ms; nd = md; np = mp;
    nc = (ms == 0 || last) ? 0 : mc + 1;
    if (ms == 0) begin
      if (acc) nd = cfg_div;
      ns = enable ? 1 : 0;
    end else if (ms == 1) begin
      if (acc) begin np = cfg_div; ns = 2; end
      if (last && !enable) begin ns = 0; if (acc) nd = cfg_div; end
    end else if (last) begin
      nd = mp;
      ns = enable ? 1 : 0;
    end
    ms = ns; mc = nc; md = nd; mp = np;
  endtask
  task automatic cyc();
    logic [12:0] e;
    model_step();
    scb.push_back({1'(ms != 0 && mc < (md + 1) / 2), 1'(ms != 0 && mc == md - 1),
                   1'(ms != 2), 1'(ms != 0), 1'(me), 8'(md)});
    @(posedge clk);
    #1;
    e = scb.pop_front();
    check("scb", {19'd0, clkout, tick, cfg_ready, busy, cfg_err, cur_div}, {19'd0, e});
  endtask
  task automatic run_pat(input int n, output logic [31:0] c, output logic [31:0] t);
    c = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      c = {c[30:0], clkout};
      t = {t[30:0], tick};
      cyc();
    end
  endtask
  task automatic adv(input int d, input int c);
    int k = 0;
    while (!(md == d && mc == c) && k < 64) begin
      cyc();
      k++;
    end
    check("adv_bound", 32'(k < 64), 1);
  endtask
  initial begin
    repeat (2) cyc();
    check("rst_clkout", clkout, 0);
    check("rst_busy", busy, 0);
    check("rst_div", cur_div, 16);
    check("rst_tick", tick, 0);
    check("rst_err", cfg_err, 0);
    reset = 1'b0;
    cfg_valid = 1'b1;
    cfg_div = 8'd0;
    cyc();
    cfg_valid = 1'b0;
    check("err_zero", cfg_err, 1);
    check("err_zero_div", cur_div, 16);
    enable = 1'b1;
    cyc();
    check("start_clk", clkout, 1);
    check("start_busy", busy, 1);
    run_pat(16, cp, tp);
    check("p16_clk", cp, 32'hFF00);
    check("p16_tick", tp, 32'h0001);
    run_pat(16, cp, tp);
    check("p16b_clk", cp, 32'hFF00);
    enable = 1'b0;
    run_pat(16, cp, tp);
    check("stop16_clk", cp, 32'hFF00);
    check("stop16_busy", busy, 0);
    check("stop16_level", clkout, 0);
    cfg_valid = 1'b1;
    cfg_div = 8'd5;
    cyc();
    cfg_valid = 1'b0;
    check("idle_cfg5", cur_div, 5);
    enable = 1'b1;
    cyc();
    run_pat(10, cp, tp);
    check("p5_clk", cp, 32'h39C);
    check("p5_tick", tp, 32'h021);
    cfg_valid = 1'b1;
    cfg_div = 8'd8;
    cyc();
    cfg_valid = 1'b0;
    adv(8, 2);
    check("rdy_run", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_div = 8'd4;
    cyc();
    cfg_div = 8'd6;
    for (int i = 0; i < 5; i++) begin
      check("rdy_pend", cfg_ready, 0);
      cyc();
    end
    check("chg_div4", cur_div, 4);
    check("rdy_after_wrap", cfg_ready, 1);
    cp0 = clkout;
    cyc();
    cfg_valid = 1'b0;
    check("second_acc", cfg_ready, 0);
    run_pat(3, cp, tp);
    check("p4_clk", {cp0, cp[2:0]}, 4'b1100);
    check("chg_div6", cur_div, 6);
    run_pat(6, cp, tp);
    check("p6_clk", cp, 32'h38);
    adv(6, 5);
    cfg_valid = 1'b1;
    cfg_div = 8'd3;
    cyc();
    cfg_valid = 1'b0;
    check("wrap_keep6", cur_div, 6);
    run_pat(6, cp, tp);
    check("wrap_p6_clk", cp, 32'h38);
    check("wrap_p6_tick", tp, 32'h1);
    check("wrap_div3", cur_div, 3);
    run_pat(3, cp, tp);
    check("p3_clk", cp, 32'h6);
    check("p3_tick", tp, 32'h1);
    cfg_valid = 1'b1;
    cfg_div = 8'd1;
    cyc();
    cfg_valid = 1'b0;
    check("err_one", cfg_err, 1);
    check("err_one_div", cur_div, 3);
    cyc();
    check("err_pulse", cfg_err, 0);
    cfg_valid = 1'b1;
    cfg_div = 8'd8;
    cyc();
    cfg_valid = 1'b0;
    adv(8, 3);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stop_busy", busy, 1);
      cyc();
    end
    check("stop_idle", busy, 0);
    check("stop_clk", clkout, 0);
    check("stop_div", cur_div, 8);
    cfg_valid = 1'b1;
    cfg_div = 8'd16;
    cyc();
    cfg_valid = 1'b0;
    check("idle_cfg16", cur_div, 16);
    enable = 1'b1;
    cyc();
    adv(16, 3);
    cfg_valid = 1'b1;
    cfg_div = 8'd10;
    cyc();
    cfg_valid = 1'b0;
    cyc();
    check("pend_rdy", cfg_ready, 0);
    reset = 1'b1;
    cyc();
    check("rstp_busy", busy, 0);
    check("rstp_div", cur_div, 16);
    check("rstp_clk", clkout, 0);
    check("rstp_rdy", cfg_ready, 1);
    reset = 1'b0;
    cyc();
    run_pat(16, cp, tp);
    check("rstp_p16", cp, 32'hFF00);
    check("rstp_lost", cur_div, 16);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
